// File: rtl/mem_arbiter_if.sv
// Memory-side bus between mem_arbiter and a single memory.
// The arbiter drives select and command; the memory returns data and ready.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH    = 16,
   parameter int DATABUS_WIDTH = 32
);
   logic                     mem_sel;
   logic                     mem_w;
   logic [ADDR_WIDTH-1:0]    mem_addr;
   logic [DATABUS_WIDTH-1:0] mem_wdata;
   logic [DATABUS_WIDTH-1:0] mem_rdata;
   logic                     mem_ready;

   modport master (
      output mem_sel, mem_w, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_sel, mem_w, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_arbiter.sv
// N-port arbiter onto one memory: fixed or round-robin grant,
// IDLE/ACCESS/DONE sequencing with optional access timeout.
module mem_arbiter #(
   parameter int NUM_PORTS      = 9,
   parameter int ADDR_WIDTH     = 16,
   parameter int DATABUS_WIDTH  = 32,
   parameter int ARB_MODE       = 1,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_PORTS-1:0]               req_ind,
   input  logic [NUM_PORTS-1:0]               w_ind,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_ind,
   input  logic [NUM_PORTS*DATABUS_WIDTH-1:0] wdata_ind,
   output logic [NUM_PORTS-1:0]               ready_ind,
   output logic [NUM_PORTS-1:0]               err_ind,
   output logic [DATABUS_WIDTH-1:0]           rdata,
   output logic                               busy,
   output logic [GW-1:0]                      grant_id,
   mem_arbiter_if.master                      mem
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TLAST =
      TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                   state;
   logic [GW-1:0]            ptr;
   logic [GW-1:0]            win;
   logic [GW-1:0]            idx;
   logic [TW-1:0]            tcnt;
   logic                     sel_q;
   logic                     w_q;
   logic [ADDR_WIDTH-1:0]    addr_q;
   logic [DATABUS_WIDTH-1:0] wdata_q;
   int                       base;

   logic [ADDR_WIDTH-1:0]    addr_arr  [NUM_PORTS];
   logic [DATABUS_WIDTH-1:0] wdata_arr [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign addr_arr[p]  = addr_ind[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[p] = wdata_ind[p*DATABUS_WIDTH +: DATABUS_WIDTH];
   end

   assign base = (ARB_MODE != 0) ? int'(ptr) : 0;

   // Scan downward so the candidate nearest to base is the last one kept.
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         idx = GW'((base + i) % NUM_PORTS);
         if (req_ind[idx]) win = idx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         tcnt      <= '0;
         grant_id  <= '0;
         sel_q     <= 1'b0;
         w_q       <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata     <= '0;
         ready_ind <= '0;
         err_ind   <= '0;
         busy      <= 1'b0;
      end else begin
         ready_ind <= '0;
         err_ind   <= '0;
         unique case (state)
            IDLE: begin
               if (|req_ind) begin
                  grant_id <= win;
                  w_q      <= w_ind[win];
                  addr_q   <= addr_arr[win];
                  wdata_q  <= wdata_arr[win];
                  tcnt     <= '0;
                  sel_q    <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               tcnt <= tcnt + 1'b1;
               // A ready on the last allowed cycle beats the timeout.
               if (mem.mem_ready) begin
                  if (!w_q) rdata <= mem.mem_rdata;
                  ready_ind[grant_id] <= 1'b1;
                  sel_q <= 1'b0;
                  state <= DONE;
               end else if (TIMEOUT_CYCLES != 0 && tcnt == TLAST) begin
                  err_ind[grant_id] <= 1'b1;
                  sel_q <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               tcnt  <= '0;
               busy  <= 1'b0;
               state <= IDLE;
               if (ARB_MODE != 0) begin
                  ptr <= (grant_id == GW'(NUM_PORTS - 1)) ?
                         '0 : grant_id + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem.mem_sel   = sel_q;
   assign mem.mem_w     = w_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: round-robin, fixed priority,
// single-port, timeout, write/read and mid-access reset.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // Instance A: 9 ports, round-robin, timeout 8
   logic [8:0]     req_a, w_a, ready_a, err_a;
   logic [143:0]   addr_a;
   logic [287:0]   wdata_a;
   logic [31:0]    rdata_a;
   logic           busy_a;
   logic [3:0]     grant_a;

   // Instance B: 4 ports, fixed priority, no timeout
   logic [3:0]     req_b, ready_b, err_b;
   logic [31:0]    rdata_b;
   logic           busy_b;
   logic [1:0]     grant_b;

   // Instance C: single port
   logic [0:0]     req_c, ready_c, err_c;
   logic [31:0]    rdata_c;
   logic           busy_c;
   logic [0:0]     grant_c;

   mem_arbiter_if #(.ADDR_WIDTH(16), .DATABUS_WIDTH(32)) ifa ();
   mem_arbiter_if #(.ADDR_WIDTH(16), .DATABUS_WIDTH(32)) ifb ();
   mem_arbiter_if #(.ADDR_WIDTH(16), .DATABUS_WIDTH(32)) ifc ();

   mem_arbiter #(
      .NUM_PORTS(9), .ADDR_WIDTH(16), .DATABUS_WIDTH(32),
      .ARB_MODE(1), .TIMEOUT_CYCLES(8)
   ) u_a (
      .clk(clk), .rst(rst), .req_ind(req_a), .w_ind(w_a),
      .addr_ind(addr_a), .wdata_ind(wdata_a), .ready_ind(ready_a),
      .err_ind(err_a), .rdata(rdata_a), .busy(busy_a),
      .grant_id(grant_a), .mem(ifa.master)
   );

   mem_arbiter #(
      .NUM_PORTS(4), .ADDR_WIDTH(16), .DATABUS_WIDTH(32),
      .ARB_MODE(0), .TIMEOUT_CYCLES(0)
   ) u_b (
      .clk(clk), .rst(rst), .req_ind(req_b), .w_ind(4'b0),
      .addr_ind(64'h0003_0002_0001_0000), .wdata_ind(128'h0),
      .ready_ind(ready_b), .err_ind(err_b), .rdata(rdata_b),
      .busy(busy_b), .grant_id(grant_b), .mem(ifb.master)
   );

   mem_arbiter #(
      .NUM_PORTS(1), .ADDR_WIDTH(16), .DATABUS_WIDTH(32),
      .ARB_MODE(1), .TIMEOUT_CYCLES(4)
   ) u_c (
      .clk(clk), .rst(rst), .req_ind(req_c), .w_ind(1'b0),
      .addr_ind(16'h0010), .wdata_ind(32'h0),
      .ready_ind(ready_c), .err_ind(err_c), .rdata(rdata_c),
      .busy(busy_c), .grant_id(grant_c), .mem(ifc.master)
   );

   // Memory model for A: programmable latency, optional stall
   logic [31:0] mem_a [0:255];
   int          cnt_a = 0;
   int          lat;
   logic        stall;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [31:0] load_data;

   always @(posedge clk) begin
      if (ifa.mem_sel) cnt_a <= cnt_a + 1;
      else             cnt_a <= 0;
      if (load_en)
         mem_a[load_addr] <= load_data;
      else if (ifa.mem_sel && ifa.mem_ready && ifa.mem_w)
         mem_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
   end

   assign ifa.mem_ready = ifa.mem_sel && !stall && (cnt_a == lat - 1);
   assign ifa.mem_rdata = mem_a[ifa.mem_addr[7:0]];

   // B and C: memory always ready, including outside ACCESS
   assign ifb.mem_ready = 1'b1;
   assign ifb.mem_rdata = 32'h0000_0055;
   assign ifc.mem_ready = 1'b1;
   assign ifc.mem_rdata = 32'h0000_00C3;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          port;
      bit          err;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   always @(negedge clk) begin
      if (rst && (|ready_a || |err_a)) begin
         if (sb.size() == 0) begin
            check("spurious", 32'(ready_a | err_a), 32'h0);
         end else begin
            e = sb.pop_front();
            check("grant", 32'(grant_a), 32'(e.port));
            check("ready", 32'(ready_a), e.err ? 32'h0 : 32'(1) << e.port);
            check("err", 32'(err_a), e.err ? 32'(1) << e.port : 32'h0);
            check("rdata", rdata_a, e.rd);
         end
      end
   end

   task automatic wait_any(output int p, output int nsel, output int ncyc);
      p = -1;
      nsel = 0;
      ncyc = 0;
      for (int k = 0; k < 64 && p < 0; k++) begin
         @(negedge clk);
         ncyc++;
         if (|ready_a || |err_a) begin
            for (int j = 0; j < 9; j++)
               if (ready_a[j] || err_a[j]) p = j;
         end else if (ifa.mem_sel) begin
            nsel++;
         end
      end
      if (p < 0) check("pulse_wait", 32'h0, 32'h1);
      else       req_a[p] = 1'b0;
   endtask

   task automatic txn(input int p, input bit w, input logic [15:0] a,
                      input logic [31:0] d, input bit ex_err,
                      input logic [31:0] rd, output int nsel,
                      output int ncyc);
      int g;
      sb.push_back('{p, ex_err, rd});
      w_a[p]             = w;
      addr_a[p*16 +: 16] = a;
      wdata_a[p*32 +: 32] = d;
      req_a[p]           = 1'b1;
      wait_any(g, nsel, ncyc);
      check("txn_port", 32'(g), 32'(p));
      @(negedge clk);
      check("idle_busy", {31'b0, busy_a}, 32'h0);
   endtask

   task automatic wait_b(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = |ready_b || |err_b;
      end
      if (!ok) check("b_wait", 32'h0, 32'h1);
   endtask

   initial begin
      int g, ns, nc;
      bit ok;
      rst = 1'b0;
      req_a = '0; w_a = '0; addr_a = '0; wdata_a = '0;
      req_b = '0; req_c = '0;
      lat = 2; stall = 1'b0;
      load_en = 1'b1; load_addr = 8'h34; load_data = 32'd7;
      repeat (2) @(negedge clk);
      load_en = 1'b0;

      check("rst_sel", {31'b0, ifa.mem_sel}, 32'h0);
      check("rst_busy", {31'b0, busy_a}, 32'h0);
      check("rst_grant", 32'(grant_a), 32'h0);
      check("rst_rdata", rdata_a, 32'h0);
      check("rst_pulse", 32'(ready_a | err_a), 32'h0);
      check("rst_addr", 32'(ifa.mem_addr), 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // Round-robin: everyone requests, re-requests after each pulse
      for (int p = 0; p < 9; p++) addr_a[p*16 +: 16] = 16'h1234;
      for (int k = 0; k < 10; k++) sb.push_back('{k % 9, 1'b0, 32'd7});
      req_a = '1;
      for (int k = 0; k < 10; k++) begin
         wait_any(g, ns, nc);
         check("rr_order", 32'(g), 32'(k % 9));
         @(negedge clk);
         if (g < 0 || k == 9) req_a = '0;
         else                 req_a[g] = 1'b1;
      end

      // Single read, 2-cycle memory: 3 cycles request-to-pulse
      txn(0, 1'b0, 16'h1234, 32'h0, 1'b0, 32'd7, ns, nc);
      check("rd_nsel", 32'(ns), 32'd2);
      check("rd_ncyc", 32'(nc), 32'd3);

      // Write keeps rdata, later read returns the written word
      txn(4, 1'b1, 16'h0200, 32'hDEAD_BEEF, 1'b0, 32'd7, ns, nc);
      check("wr_nsel", 32'(ns), 32'd2);
      txn(1, 1'b0, 16'h0200, 32'h0, 1'b0, 32'hDEAD_BEEF, ns, nc);

      // Timeout: 8 ACCESS cycles then an error, rdata untouched
      stall = 1'b1;
      txn(4, 1'b0, 16'h1234, 32'h0, 1'b1, 32'hDEAD_BEEF, ns, nc);
      check("to_nsel", 32'(ns), 32'd8);
      check("to_ncyc", 32'(nc), 32'd9);
      stall = 1'b0;

      // Request dropped mid-ACCESS still completes
      sb.push_back('{6, 1'b0, 32'd7});
      w_a[6] = 1'b0;
      addr_a[6*16 +: 16] = 16'h1234;
      req_a[6] = 1'b1;
      @(negedge clk);
      check("drop_sel", {31'b0, ifa.mem_sel}, 32'h1);
      req_a[6] = 1'b0;
      wait_any(g, ns, nc);
      check("drop_port", 32'(g), 32'd6);
      @(negedge clk);

      // Ready on the final timeout cycle wins
      lat = 8;
      txn(3, 1'b0, 16'h1234, 32'h0, 1'b0, 32'd7, ns, nc);
      check("edge_nsel", 32'(ns), 32'd8);
      lat = 2;

      // Reset mid-ACCESS abandons the access and clears ptr
      stall = 1'b1;
      req_a[3] = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_rst_sel", {31'b0, ifa.mem_sel}, 32'h1);
      rst = 1'b0;
      #1;
      check("arst_sel", {31'b0, ifa.mem_sel}, 32'h0);
      check("arst_busy", {31'b0, busy_a}, 32'h0);
      check("arst_grant", 32'(grant_a), 32'h0);
      check("arst_rdata", rdata_a, 32'h0);
      req_a = '0;
      stall = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      addr_a[2*16 +: 16] = 16'h1234;
      addr_a[5*16 +: 16] = 16'h1234;
      w_a = '0;
      sb.push_back('{2, 1'b0, 32'd7});
      sb.push_back('{5, 1'b0, 32'd7});
      req_a[2] = 1'b1;
      req_a[5] = 1'b1;
      wait_any(g, ns, nc);
      check("post_rst_first", 32'(g), 32'd2);
      wait_any(g, ns, nc);
      check("post_rst_second", 32'(g), 32'd5);
      @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'h0);

      // Fixed priority: port 0 always wins over port 3
      req_b = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         wait_b(ok);
         check("fp_grant", 32'(grant_b), 32'h0);
         check("fp_ready", 32'(ready_b | err_b), 32'h1);
      end
      req_b[0] = 1'b0;
      wait_b(ok);
      check("fp_grant3", 32'(grant_b), 32'h3);
      check("fp_ready3", 32'(ready_b), 32'h8);
      check("fp_rdata", rdata_b, 32'h55);
      req_b = '0;

      // Single-port instance
      req_c = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = ready_c[0] || err_c[0];
      end
      if (!ok) check("c_wait", 32'h0, 32'h1);
      req_c = 1'b0;
      check("c_grant", 32'(grant_c), 32'h0);
      check("c_ready", 32'(ready_c), 32'h1);
      check("c_rdata", rdata_c, 32'hC3);
      @(negedge clk);
      check("c_busy", {31'b0, busy_c}, 32'h0);
      check("b_busy", {31'b0, busy_b}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run still active, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter NUM_PORTS, 9, number of requester ports (minimum 1).
REQ-002 SHALL have parameter ADDR_WIDTH, 16, address width.
REQ-003 SHALL have parameter DATABUS_WIDTH, 32, data width.
REQ-004 SHALL have parameter ARB_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 16, maximum ACCESS cycles allowed; 0 disables the timeout.
Ports (name, direction, width, meaning):
REQ-006 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port req_ind, input, NUM_PORTS, per-port access request.
REQ-009 SHALL have port w_ind, input, NUM_PORTS, per-port write enable (1 = write).
REQ-010 SHALL have port addr_ind, input, NUM_PORTS*ADDR_WIDTH, flattened addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port wdata_ind, input, NUM_PORTS*DATABUS_WIDTH, flattened write data, same packing.
REQ-012 SHALL have port ready_ind, output, NUM_PORTS, one-cycle completion pulse per port.
REQ-013 SHALL have port err_ind, output, NUM_PORTS, one-cycle timeout pulse per port.
REQ-014 SHALL have port rdata, output, DATABUS_WIDTH, last read data, broadcast to all ports.
REQ-015 SHALL have ports mem_sel (output, 1), mem_w (output, 1), mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATABUS_WIDTH), mem_rdata (input, DATABUS_WIDTH), mem_ready (input, 1), forming the memory-side interface.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port grant_id, output, max(1,clog2(NUM_PORTS)), index of the current or last granted port.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-019 In IDLE with any req_ind bit set, SHALL select a winner, register the winner's w, addr and wdata plus grant_id, and enter ACCESS on the next edge.
REQ-020 In IDLE with no request, SHALL remain in IDLE with mem_sel = 0.
REQ-021 Round-robin mode SHALL search from priority pointer ptr upward with wrap-around modulo NUM_PORTS; fixed mode SHALL ignore ptr.
REQ-022 In ACCESS, SHALL drive mem_sel = 1 and hold mem_w, mem_addr and mem_wdata constant from the registered copies.
REQ-023 In ACCESS, SHALL increment a timeout counter each cycle, starting at 0.
REQ-024 In ACCESS with mem_ready = 1, SHALL capture mem_rdata into rdata on reads only and enter DONE; writes SHALL leave rdata unchanged.
REQ-025 In ACCESS, if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES without mem_ready, SHALL enter DONE flagged as error and leave rdata unchanged.
REQ-026 If mem_ready and timeout coincide, mem_ready SHALL win and no error is flagged.
REQ-027 In DONE, SHALL drive mem_sel = 0 and pulse exactly one of ready_ind[grant_id] or err_ind[grant_id] for one cycle, then return to IDLE.
REQ-028 On leaving DONE in round-robin mode, SHALL set ptr = (grant_id+1) mod NUM_PORTS, on both success and error.
REQ-029 SHALL ignore mem_ready in IDLE and DONE.
REQ-030 Once granted, a transaction SHALL complete and pulse its port even if that port drops req_ind mid-ACCESS.
REQ-031 A requester SHALL drop req_ind on the edge at which it samples ready_ind or err_ind; a req_ind still high in the following IDLE cycle is a new request.
REQ-032 Latency SHALL be: req_ind sampled in IDLE at cycle 0, mem_sel high from cycle 1, ready pulse on the cycle after mem_ready is sampled; minimum 3 cycles per transaction.
REQ-033 With NUM_PORTS = 1, SHALL always grant port 0, with grant_id 1 bit wide and held 0.

Reset
REQ-034 On rst = 0, SHALL asynchronously force state IDLE, ptr 0, timeout counter 0, and drive all outputs to 0 (ready_ind, err_ind, rdata, mem_sel, mem_w, mem_addr, mem_wdata, busy, grant_id).
REQ-035 Reset during ACCESS SHALL abandon the transaction without any ready or error pulse; arbitration resumes normally after release.

Verification
REQ-036 Single read test: port 0 reads 0x1234, memory LATENCY 2, memory holds 7 -> mem_sel high until mem_ready, then ready_ind[0] pulses once and rdata = 7.
REQ-037 Round-robin test: all 9 ports request simultaneously and re-request after each ready -> grant_id sequence 0,1,...,8,0, and no port is served twice before all are served.
REQ-038 Fixed-priority test (ARB_MODE = 0): ports 0 and 3 request continuously -> port 0 is granted every time and port 3 is never granted while port 0 is requesting.
REQ-039 Timeout test: mem_ready tied 0, TIMEOUT_CYCLES = 8 -> err_ind pulses after 8 ACCESS cycles, no ready_ind pulse, rdata unchanged.
REQ-040 Reset test: rst asserted mid-ACCESS -> mem_sel = 0 immediately; after release with ports 2 and 5 requesting, port 2 is granted (ptr = 0).
REQ-041 Write-then-read test: port 4 writes 0xDEADBEEF to 0x0200, then port 1 reads 0x0200 -> rdata = 0xDEADBEEF, and rdata is unchanged after the write alone.
